// File: rtl/psi_seq_ctrl_if.sv
// Party-input and result streams of the PSI sequencer, grouped so producer and
// consumer hook up through one port.
interface psi_seq_ctrl_if #(
    parameter int B = 10
);
    localparam int CW = $clog2(B + 1);

    logic          in_valid;
    logic          in_ready;
    logic [B-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [B-1:0]  out_set;
    logic [CW-1:0] out_card;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_set, out_card
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_set, out_card
    );
endinterface

// File: rtl/psi_seq_ctrl.sv
// Sequential PSI controller: folds N serially arriving party bitmaps into a
// running AND and reports the intersection bitmap plus its popcount.
module psi_seq_ctrl #(
    parameter int B = 10,
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    psi_seq_ctrl_if.slave bus
);
    localparam int CW    = $clog2(B + 1);
    localparam int CNT_W = $clog2(N);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]       state_reg;
    logic [B-1:0]     acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [B-1:0]     out_set_reg;
    logic [CW-1:0]    out_card_reg;
    logic             busy_reg;

    logic [B-1:0]     acc_next;
    logic [CW-1:0]    card_next;
    logic             beat;

    assign beat     = bus.in_valid & in_ready_reg;
    assign acc_next = acc_reg & bus.in_data;

    always_comb begin
        card_next = '0;
        for (int i = 0; i < B; i++) begin
            card_next = card_next + CW'(acc_next[i]);
        end
    end

    // Every beat is folded the same way regardless of acc's value, so the
    // number of cycles to a result never depends on the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            acc_reg       <= '1;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_set_reg   <= '0;
            out_card_reg  <= '0;
            busy_reg      <= 1'b0;
        end else if (abort) begin
            state_reg     <= S_IDLE;
            acc_reg       <= '1;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg    <= S_COLLECT;
                        acc_reg      <= '1;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (beat) begin
                        acc_reg <= acc_next;
                        if (cnt_reg == CNT_W'(N - 1)) begin
                            cnt_reg       <= '0;
                            out_set_reg   <= acc_next;
                            out_card_reg  <= card_next;
                            out_valid_reg <= 1'b1;
                            in_ready_reg  <= 1'b0;
                            state_reg     <= S_DONE;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    // start is deliberately not looked at here, even on the handshake cycle
                    if (out_valid_reg && bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= S_IDLE;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_set   = out_set_reg;
    assign bus.out_card  = out_card_reg;
    assign busy          = busy_reg;
endmodule

// File: tb/tb_psi_seq_ctrl.sv
// Directed bench for psi_seq_ctrl: a transaction-level model (accepted-beat queue
// reduced by AND) is compared against the DUT on every falling clock edge.
module tb_psi_seq_ctrl;
    localparam int B  = 10;
    localparam int N  = 4;
    localparam int CW = $clog2(B + 1);

    logic clk;
    logic rst_n;
    logic start;
    logic abort;
    logic busy;

    psi_seq_ctrl_if #(.B(B)) bus ();

    psi_seq_ctrl #(.B(B), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a run is "collecting" until N beats sit in the queue, then "done"
    // until the consumer takes the result.
    bit            m_collect = 1'b0;
    bit            m_done    = 1'b0;
    logic [B-1:0]  beats[$];
    logic [B-1:0]  m_set  = '0;
    logic [CW-1:0] m_card = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_collect = 1'b0;
            m_done    = 1'b0;
            beats.delete();
            m_set  = '0;
            m_card = '0;
        end else if (abort) begin
            m_collect = 1'b0;
            m_done    = 1'b0;
            beats.delete();
        end else if (m_collect) begin
            if (bus.in_valid) begin
                beats.push_back(bus.in_data);
                if (beats.size() == N) begin
                    m_set = '1;
                    foreach (beats[i]) m_set &= beats[i];
                    m_card    = CW'($countones(m_set));
                    m_collect = 1'b0;
                    m_done    = 1'b1;
                end
            end
        end else if (m_done) begin
            if (bus.out_ready) m_done = 1'b0;
        end else if (start) begin
            m_collect = 1'b1;
            beats.delete();
        end
    end

    always @(negedge clk) begin
        chk("in_ready",  32'(bus.in_ready),  32'(m_collect));
        chk("out_valid", 32'(bus.out_valid), 32'(m_done));
        chk("busy",      32'(busy),          32'(m_collect | m_done));
        chk("out_set",   32'(bus.out_set),   32'(m_set));
        chk("out_card",  32'(bus.out_card),  32'(m_card));
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [B-1:0] d, input int gap);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_valid(input string name, input int t0, output int lat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        if (!bus.out_valid) chk({name, "_timeout"}, 32'(0), 32'(1));
        lat = cyc - t0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic run_set(input string name, input logic [B-1:0] d0, input logic [B-1:0] d1,
                           input logic [B-1:0] d2, input logic [B-1:0] d3, input int gap,
                           output int lat);
        int t0;
        t0 = cyc;
        do_start();
        send_beat(d0, gap);
        send_beat(d1, gap);
        send_beat(d2, gap);
        send_beat(d3, gap);
        wait_valid(name, t0, lat);
    endtask

    task automatic async_reset_check(input string name);
        #3 rst_n = 1'b0;
        #1;
        chk({name, "_in_ready"},  32'(bus.in_ready),  32'(0));
        chk({name, "_out_valid"}, 32'(bus.out_valid), 32'(0));
        chk({name, "_busy"},      32'(busy),          32'(0));
        chk({name, "_out_set"},   32'(bus.out_set),   32'(0));
        chk({name, "_out_card"},  32'(bus.out_card),  32'(0));
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    int lat1, lat3, lat_tmp;

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        chk("reset_out_set", 32'(bus.out_set), 32'(0));
        rst_n = 1'b1;
        tick();

        // 1. basic
        run_set("s1", 10'h3FF, 10'h2AA, 10'h0AF, 10'h0FF, 0, lat1);
        chk("s1_set",  32'(bus.out_set),  32'h0AA);
        chk("s1_card", 32'(bus.out_card), 32'd4);
        chk("s1_lat",  32'(lat1),         32'd5);
        $display("txn s1 set=%03h card=%0d lat=%0d", bus.out_set, bus.out_card, lat1);
        handshake();
        tick();

        // 2. gaps and backpressure
        run_set("s2", 10'h3FF, 10'h2AA, 10'h0AF, 10'h0FF, 2, lat_tmp);
        repeat (5) tick();
        chk("s2_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("s2_set",        32'(bus.out_set),   32'h0AA);
        chk("s2_card",       32'(bus.out_card),  32'd4);
        $display("txn s2 set=%03h card=%0d", bus.out_set, bus.out_card);
        handshake();
        tick();

        // 3. constant time with an early zero
        run_set("s3", 10'h000, 10'h3FF, 10'h3FF, 10'h3FF, 0, lat3);
        chk("s3_set",  32'(bus.out_set),  32'h000);
        chk("s3_card", 32'(bus.out_card), 32'd0);
        chk("s3_lat",  32'(lat3),         32'(lat1));
        $display("txn s3 set=%03h card=%0d lat=%0d", bus.out_set, bus.out_card, lat3);
        handshake();
        tick();

        // 4. abort mid-collect, then a clean run
        do_start();
        send_beat(10'h3FF, 0);
        send_beat(10'h2AA, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s4_in_ready", 32'(bus.in_ready), 32'd0);
        chk("s4_busy",     32'(busy),         32'd0);
        tick();
        run_set("s4b", 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 0, lat_tmp);
        chk("s4_set",  32'(bus.out_set),  32'h3FF);
        chk("s4_card", 32'(bus.out_card), 32'd10);
        $display("txn s4 set=%03h card=%0d", bus.out_set, bus.out_card);
        handshake();
        tick();

        // 5. async reset in COLLECT and in DONE
        do_start();
        send_beat(10'h155, 0);
        async_reset_check("s5_collect");
        run_set("s5", 10'h3F0, 10'h3FF, 10'h0FF, 10'h3FF, 0, lat_tmp);
        chk("s5_set", 32'(bus.out_set), 32'h0F0);
        async_reset_check("s5_done");
        $display("txn s5 reset in COLLECT and DONE");

        // 6a. start inside COLLECT and DONE is ignored
        do_start();
        send_beat(10'h3FF, 0);
        start = 1'b1;
        send_beat(10'h1FF, 0);
        send_beat(10'h0FF, 0);
        send_beat(10'h07F, 0);
        wait_valid("s6a", cyc, lat_tmp);
        repeat (2) tick();
        start = 1'b0;
        chk("s6a_set",  32'(bus.out_set),  32'h07F);
        chk("s6a_card", 32'(bus.out_card), 32'd7);
        $display("txn s6a set=%03h card=%0d", bus.out_set, bus.out_card);

        // 6b. start coincident with the out handshake
        start = 1'b1;
        handshake();
        start = 1'b0;
        tick();
        chk("s6b_busy", 32'(busy), 32'd0);
        $display("txn s6b busy=%0d", busy);

        // 6c. abort coincident with the 4th beat
        do_start();
        send_beat(10'h3FF, 0);
        send_beat(10'h3FF, 0);
        send_beat(10'h3FF, 0);
        abort = 1'b1;
        send_beat(10'h3FF, 0);
        abort = 1'b0;
        tick();
        chk("s6c_out_valid", 32'(bus.out_valid), 32'd0);
        chk("s6c_set_kept",  32'(bus.out_set),   32'h07F);
        $display("txn s6c out_valid=%0d", bus.out_valid);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
